// File: rtl/reset_pkg.sv
// reset_pkg: state encoding and counter sizing shared by the reset conditioner
package reset_pkg;
  localparam logic [1:0] ASSERT   = 2'd0;
  localparam logic [1:0] WAIT_REL = 2'd1;
  localparam logic [1:0] HOLD     = 2'd2;
  localparam logic [1:0] RUN      = 2'd3;
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/sync_chain.sv
// sync_chain: DEPTH-flop synchronizer with asynchronous active-low clear
module sync_chain #(
  parameter int   DEPTH   = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic CLK,
  input  logic RESET,
  input  logic d,
  output logic q
);
  logic [DEPTH-1:0] r;
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) r <= {DEPTH{RST_VAL}};
    else r <= {r[DEPTH-2:0], d};
  assign q = r[DEPTH-1];
endmodule

// File: rtl/reset_conditioner.sv
// reset_conditioner: stretched, synchronously released reset with debounced manual re-trigger
module reset_conditioner
  import reset_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int HOLD_CYCLES     = 16,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic CLK,
  input  logic RESET,
  input  logic BTN,
  output logic resetn,
  output logic ready,
  output logic ready_pulse,
  output logic btn_event
);
  localparam int HW = cnt_w(HOLD_CYCLES);
  localparam int DW = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  if (SYNC_STAGES < 2 || HOLD_CYCLES < 1 || DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
    $error("reset_conditioner: parameter below its minimum");
  end
  logic rel_s, btn_s, btn_db, db_hit, db_rise;
  logic [1:0] state, nxt;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic [DW-1:0] db_cnt;
  sync_chain #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_rel_sync (.CLK, .RESET, .d(1'b1), .q(rel_s));
  sync_chain #(.DEPTH(2), .RST_VAL(1'b0)) u_btn_sync (.CLK, .RESET, .d(BTN), .q(btn_s));
  assign db_hit  = (btn_s != btn_db) && (db_cnt == DB_LAST);
  assign db_rise = db_hit && !btn_db;
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      btn_db <= 1'b0;
      db_cnt <= '0;
    end else if (btn_s == btn_db || db_hit) begin
      btn_db <= btn_db ^ db_hit;
      db_cnt <= '0;
    end else db_cnt <= db_cnt + 1'b1;
  // The cycle that enters HOLD already counts as the first hold cycle.
  always_comb begin
    nxt      = state;
    hold_nxt = hold_cnt;
    case (state)
      ASSERT: if (rel_s) begin
        nxt      = (HOLD_LAST == '0) ? RUN : HOLD;
        hold_nxt = '0;
      end
      HOLD: begin
        hold_nxt = db_rise ? '0 : hold_cnt + 1'b1;
        nxt      = db_rise ? WAIT_REL : (hold_nxt == HOLD_LAST) ? RUN : HOLD;
      end
      RUN: if (db_rise) begin
        nxt      = WAIT_REL;
        hold_nxt = '0;
      end
      WAIT_REL: begin
        hold_nxt = '0;
        nxt      = btn_db ? WAIT_REL : (HOLD_LAST == '0) ? RUN : HOLD;
      end
    endcase
  end
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      state       <= ASSERT;
      hold_cnt    <= '0;
      resetn      <= 1'b0;
      ready       <= 1'b0;
      ready_pulse <= 1'b0;
      btn_event   <= 1'b0;
    end else begin
      state       <= nxt;
      hold_cnt    <= hold_nxt;
      resetn      <= nxt == RUN;
      ready       <= nxt == RUN;
      ready_pulse <= nxt == RUN && state != RUN;
      btn_event   <= db_rise && (state == RUN || state == HOLD);
    end
endmodule

// File: tb/tb_reset_conditioner.sv
// tb_reset_conditioner: directed checks of release latency, debounce and press handling
module tb_reset_conditioner;
  logic CLK = 1'b0, RESET = 1'b0, BTN = 1'b0, RESET2 = 1'b0, BTN2 = 1'b0, use2 = 1'b0;
  logic resetn, ready, ready_pulse, btn_event;
  logic resetn2, ready2, ready_pulse2, btn_event2;
  int checks = 0, errors = 0, ev = 0, rp = 0, hi = 0, n = 0;
  always #5 CLK = ~CLK;
  reset_conditioner u_dut (
    .CLK(CLK), .RESET(RESET), .BTN(BTN), .resetn(resetn), .ready(ready),
    .ready_pulse(ready_pulse), .btn_event(btn_event)
  );
  reset_conditioner #(.SYNC_STAGES(3), .HOLD_CYCLES(16), .DEBOUNCE_CYCLES(4)) u_small (
    .CLK(CLK), .RESET(RESET2), .BTN(BTN2), .resetn(resetn2), .ready(ready2),
    .ready_pulse(ready_pulse2), .btn_event(btn_event2)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick(input int k);
    repeat (k) @(posedge CLK);
    #1;
  endtask
  task automatic clear();
    ev = 0;
    rp = 0;
    hi = 0;
  endtask
  task automatic run(input int k);
    repeat (k) begin
      tick(1);
      ev += int'(use2 ? btn_event2 : btn_event);
      rp += int'(use2 ? ready_pulse2 : ready_pulse);
      hi += int'(use2 ? resetn2 : resetn);
    end
  endtask
  task automatic wait_rise(input int bound, output int k);
    k = 0;
    while (!(use2 ? resetn2 : resetn) && k < bound) begin
      tick(1);
      k++;
    end
  endtask
  task automatic wait_event(input int bound, output int k);
    k = 0;
    while (!(use2 ? btn_event2 : btn_event) && k < bound) begin
      tick(1);
      k++;
    end
  endtask
  initial begin
    tick(5);
    check("rst_resetn", resetn, 0);
    check("rst_ready", ready, 0);
    check("rst_pulse", ready_pulse, 0);
    check("rst_event", btn_event, 0);
    RESET = 1'b1;
    wait_rise(100, n);
    check("t1_latency", n, 18);
    check("t1_pulse", ready_pulse, 1);
    check("t1_ready", ready, 1);
    clear();
    run(20);
    check("t1_pulse_once", rp, 0);
    check("t1_ready_stays", hi, 20);
    RESET = 1'b0;
    #1;
    check("t2_async_resetn", resetn, 0);
    check("t2_async_ready", ready, 0);
    tick(3);
    RESET = 1'b1;
    tick(11);
    RESET = 1'b0;
    tick(2);
    RESET = 1'b1;
    wait_rise(100, n);
    check("t2_relatency", n, 18);
    check("t2_pulse", ready_pulse, 1);
    clear();
    BTN = 1'b1;
    run(500);
    BTN = 1'b0;
    run(5);
    check("t3_no_event", ev, 0);
    check("t3_resetn_high", hi, 505);
    BTN = 1'b1;
    wait_event(1200, n);
    check("t4_event_delay", n, 1002);
    check("t4_resetn_low", resetn, 0);
    check("t4_ready_low", ready, 0);
    clear();
    run(1997);
    check("t4_single_event", ev, 0);
    check("t4_held_low", hi, 0);
    BTN = 1'b0;
    wait_rise(1100, n);
    check("t4_release", n, 1018);
    check("t4_pulse", ready_pulse, 1);
    clear();
    repeat (20) begin
      BTN = ~BTN;
      run(100);
    end
    BTN = 1'b1;
    run(1500);
    check("t5_events", ev, 1);
    BTN = 1'b0;
    wait_rise(1100, n);
    check("t5_recover", n, 1018);
    use2 = 1'b1;
    check("s_rst_state", {resetn2, ready2, ready_pulse2, btn_event2}, 0);
    RESET2 = 1'b1;
    tick(13);
    BTN2 = 1'b1;
    tick(6);
    check("sim_event", btn_event2, 1);
    check("sim_resetn", resetn2, 0);
    check("sim_no_pulse", ready_pulse2, 0);
    clear();
    run(10);
    check("sim_wait_rel", hi + rp, 0);
    BTN2 = 1'b0;
    wait_rise(100, n);
    check("sim_release", n, 22);
    clear();
    BTN2 = 1'b1;
    run(3);
    BTN2 = 1'b0;
    run(10);
    check("glitch_no_event", ev, 0);
    check("glitch_resetn", hi, 13);
    clear();
    BTN2 = 1'b1;
    run(4);
    BTN2 = 1'b0;
    run(10);
    check("edge_event", ev, 1);
    wait_rise(100, n);
    check("edge_recover", n, 12);
    RESET2 = 1'b0;
    tick(2);
    check("t6_reset", resetn2, 0);
    RESET2 = 1'b1;
    BTN2 = 1'b1;
    wait_event(100, n);
    check("t6_event_delay", n, 6);
    check("t6_resetn_low", resetn2, 0);
    clear();
    run(30);
    check("t6_wait_rel", hi, 0);
    BTN2 = 1'b0;
    wait_rise(100, n);
    check("t6_full_hold", n, 22);
    check("t6_pulse", ready_pulse2, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
